pipelined_prefix_adder: RTL and testbench

- Parametrised, pipelined Kogge-Stone prefix adder/subtractor with valid/ready handshakes on both sides.
- One register rank per prefix level gives a throughput of one operation per clock at high fmax.
- Used as the arithmetic core for wide datapaths in later labs; it replaces the purely combinational prefix adder wherever timing closure requires pipelining.

---
 rtl/prefix_pkg.sv | 17 +
 rtl/prefix_level.sv | 24 ++
 rtl/pipelined_prefix_adder.sv | 104 ++++++++++
 tb/tb_pipelined_prefix_adder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder: level spans, level count
// from width, and the pipeline latency derived from the level count.
package prefix_pkg;

  function automatic int unsigned span(input int unsigned k);
    return 32'd1 << (k - 32'd1);
  endfunction

  function automatic int unsigned levels_for_width(input int unsigned w);
    return $clog2(w);
  endfunction

  function automatic int unsigned latency_for(input int unsigned levels);
    return levels + 32'd1;
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone level: merges each (G,P) pair with the pair
// SPAN bits below it; the lowest SPAN bits pass through unchanged.
module prefix_level
  import prefix_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SPAN  = 1
) (
  input  logic [WIDTH-1:0] i_g,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_g,
  output logic [WIDTH-1:0] o_p
);

  always_comb begin
    o_g = i_g;
    o_p = i_p;
    for (int unsigned i = SPAN; i < WIDTH; i++) begin
      o_g[i] = i_g[i] | (i_p[i] & i_g[i-SPAN]);
      o_p[i] = i_p[i] & i_p[i-SPAN];
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor: one register rank per prefix level,
// valid/ready on both sides, whole pipeline stalls on output backpressure.
module pipelined_prefix_adder
  import prefix_pkg::*;
#(
  parameter int unsigned LEVELS = 3,
  parameter int unsigned WIDTH  = 2**LEVELS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned LATENCY = latency_for(LEVELS);
  localparam int unsigned LAST    = LEVELS;

  if (LEVELS < 1 || WIDTH != (32'd1 << LEVELS) || levels_for_width(WIDTH) != LEVELS) begin : g_width_check
    $error("pipelined_prefix_adder: WIDTH must equal 2**LEVELS with LEVELS >= 1");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g_in;
  logic [WIDTH-1:0] w_g_nxt  [LATENCY];
  logic [WIDTH-1:0] w_gp_nxt [LATENCY];
  logic [WIDTH-1:0] w_gout;

  logic [WIDTH-1:0] r_g   [LATENCY];
  logic [WIDTH-1:0] r_gp  [LATENCY];
  logic [WIDTH-1:0] r_p   [LATENCY];
  logic             r_cin [LATENCY];
  logic             r_vld [LATENCY];

  // Single advance enable: every rank, bubbles included, moves or holds together.
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_y       = op_sub ? ~y : y;
    w_cin     = op_sub | carry_in;
    w_p       = x ^ w_y;
    w_g_in    = x & w_y;
    w_g_in[0] = w_g_in[0] | (w_p[0] & w_cin);
  end

  assign w_g_nxt[0]  = w_g_in;
  assign w_gp_nxt[0] = w_p;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (span(k))
    ) u_level (
      .i_g (r_g[k-1]),
      .i_p (r_gp[k-1]),
      .o_g (w_g_nxt[k]),
      .o_p (w_gp_nxt[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        r_g[k]   <= '0;
        r_gp[k]  <= '0;
        r_p[k]   <= '0;
        r_cin[k] <= 1'b0;
        r_vld[k] <= 1'b0;
      end
    end else if (w_adv) begin
      for (int unsigned k = 0; k < LATENCY; k++) begin
        r_g[k]  <= w_g_nxt[k];
        r_gp[k] <= w_gp_nxt[k];
      end
      r_p[0]   <= w_p;
      r_cin[0] <= w_cin;
      r_vld[0] <= in_valid;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        r_p[k]   <= r_p[k-1];
        r_cin[k] <= r_cin[k-1];
        r_vld[k] <= r_vld[k-1];
      end
    end
  end

  assign w_gout    = r_g[LAST];
  assign out_valid = r_vld[LAST];
  assign z         = {r_p[LAST][WIDTH-1:1] ^ w_gout[WIDTH-2:0], r_p[LAST][0] ^ r_cin[LAST]};
  assign carry_out = w_gout[WIDTH-1];
  assign overflow  = w_gout[WIDTH-2] ^ w_gout[WIDTH-1];

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder (LEVELS=3, WIDTH=8): directed
// vectors with literal expectations plus an arithmetic scoreboard on every output.
module tb_pipelined_prefix_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       op_sub;
  logic       carry_in;
  logic [7:0] x;
  logic [7:0] y;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] z;
  logic       carry_out;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit lat_chk = 1'b1;
  bit rnd_done = 1'b0;

  typedef struct {
    logic [9:0] exp;
    int         acc;
  } beat_t;
  beat_t q[$];

  pipelined_prefix_adder #(.LEVELS(3), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .carry_in  (carry_in),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result packed as {overflow, carry_out, z}, from plain 9-bit arithmetic.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic sub, input logic ci);
    logic [7:0] bb;
    logic [8:0] s;
    logic       ov;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {8'd0, (sub | ci)};
    ov = (a[7] == bb[7]) && (s[7] != a[7]);
    return {ov, s[8], s[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_res(input string name, input logic [9:0] exp);
    chk(name, 32'({overflow, carry_out, z}), 32'(exp));
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic ci);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    x = a; y = b; op_sub = sub; carry_in = ci; in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("send_timeout", 32'(got), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(out_valid), 32'd1);
  endtask

  // Scoreboard: peek head on every valid cycle (stall included), pop on handshake.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(q.size()), 32'd1);
        end else begin
          e = q[0];
          chk("stream_result", 32'({overflow, carry_out, z}), 32'(e.exp));
          if (out_ready) begin
            if (lat_chk) chk("latency", 32'(cyc + 1 - e.acc), 32'd4);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) q.push_back('{model(x, y, op_sub, carry_in), cyc + 1});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; carry_in = 1'b0;
    x = '0; y = '0; out_ready = 1'b0;

    chk("model_add",  32'(model(8'h0F, 8'h01, 1'b0, 1'b0)), 32'h010);
    chk("model_cin",  32'(model(8'hFF, 8'h00, 1'b0, 1'b1)), 32'h100);
    chk("model_sub",  32'(model(8'h05, 8'h07, 1'b1, 1'b0)), 32'h0FE);
    chk("model_sovf", 32'(model(8'h80, 8'h01, 1'b1, 1'b1)), 32'h37F);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk_res("rst_data", 10'h000);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Latency: accepted at edge T, valid after edge T+3.
    send(8'h0F, 8'h01, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk_res("t1_result", 10'h010);
    @(posedge clk);
    #1;

    send(8'hFF, 8'h00, 1'b0, 1'b1);
    wait_valid("t2a_wait");
    chk_res("t2a_result", 10'h100);
    @(posedge clk); #1;
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_valid("t2b_wait");
    chk_res("t2b_result", 10'h280);
    @(posedge clk); #1;

    send(8'h05, 8'h07, 1'b1, 1'b0);
    wait_valid("t3a_wait");
    chk_res("t3a_result", 10'h0FE);
    @(posedge clk); #1;
    send(8'h80, 8'h01, 1'b1, 1'b1);
    wait_valid("t3b_wait");
    chk_res("t3b_result", 10'h37F);
    @(posedge clk); #1;

    for (int i = 0; i < 100; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
    repeat (6) @(posedge clk);
    #1;

    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'(i * 17), 8'(i * 3 + 1), i[0], 1'b1);
      end
      begin
        int m;
        m = 0;
        while (!out_valid && m < 50) begin
          @(posedge clk);
          #1;
          m++;
        end
        chk("bp_start_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          while ($urandom_range(1) == 1) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom), 8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        rnd_done = 1'b1;
      end
      begin
        int m;
        m = 0;
        while (!rnd_done && m < 20000) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(1));
          m++;
        end
      end
    join

    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Async reset with one result at the output and three more in flight.
    lat_chk = 1'b1;
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    send(8'h55, 8'h66, 1'b1, 1'b0);
    send(8'h77, 8'h08, 1'b0, 1'b1);
    #1;
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk_res("t6_async_data", 10'h000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("t6_no_stale", 32'(out_valid), 32'd0);
    end
    send(8'h3C, 8'h0A, 1'b1, 1'b0);
    wait_valid("t6_wait");
    chk_res("t6_result", 10'h132);
    @(posedge clk);
    #1;
    chk("t6_end_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
